cdr_cp_ctrl: RTL and testbench
==============================

Name: cdr_cp_ctrl

Overview:
- Digital sequencer that drives the `up`/`down` control inputs of the CDR charge pump (`dms_cp`).
- Accumulates early/late votes from the bang-bang phase detector and issues bounded, mutually exclusive up or down pulses of programmable width, with a guard gap between pulses.
- Flags lock when no correction pulse has been needed for a programmable-length quiet window.
- Sits between the phase detector and the charge pump in the CDR loop.

Parameters:
- VOTE_W, 4: width of the signed vote accumulator; usable range ±(2^(VOTE_W-1)-1).
- PULSE_W, 4: width of the pulse-length input and pulse counter.
- LOCK_CNT, 64: number of consecutive quiet ACCUM cycles required to assert `locked`.
- LOCK_W, 7: width of the lock counter; must satisfy 2^LOCK_W > LOCK_CNT.

Ports:
- clk  input  1  loop clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  controller enable.
- early  input  1  phase-detector early vote; valid every cycle.
- late  input  1  phase-detector late vote; valid every cycle.
- vote_thr  input  VOTE_W-1  vote magnitude that triggers a pulse; 0 is treated as 1.
- pulse_len  input  PULSE_W  pulse width in clk cycles; 0 is treated as 1.
- up  output  1  charge-pump up switch; registered.
- down  output  1  charge-pump down switch; registered.
- busy  output  1  high in PULSE_UP, PULSE_DN and GUARD.
- locked  output  1  quiet-window lock indication.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; vote, pulse counter and lock counter all 0.
  - `up`, `down`, `busy`, `locked` all 0.
- State encoding: IDLE, ACCUM, PULSE_UP, PULSE_DN, GUARD.
- Priority: `en`=0 in any state forces IDLE on the next edge. `up`, `down` and `locked` are cleared on that same edge, and vote and counters are reset.
- IDLE:
  - Outputs 0.
  - `en`=1 -> ACCUM next edge, vote cleared.
- ACCUM, vote update each cycle:
  - `early`&!`late` -> +1.
  - `late`&!`early` -> −1.
  - both high or both low -> no change.
  - The vote saturates at ±(2^(VOTE_W-1)-1) and never wraps.
- ACCUM, pulse trigger: let vnext be the updated vote and thr_eff = max(`vote_thr`,1).
  - vnext ≥ +thr_eff -> PULSE_UP. `up`=1 from the same edge; latch len_eff = max(`pulse_len`,1) and load the pulse counter.
  - vnext ≤ −thr_eff -> PULSE_DN. Same rules, driving `down`.
  - Otherwise stay in ACCUM with vote = vnext.
- Latency: with thr_eff=1, an early vote sampled at edge N gives `up`=1 after edge N.
- PULSE_UP / PULSE_DN:
  - The active output is high for exactly len_eff cycles, and the PD inputs are ignored.
  - When the counter expires -> GUARD; the output drops on the same edge.
- GUARD:
  - Exactly 1 cycle with `up`=`down`=0.
  - Then -> ACCUM with vote cleared to 0.
- Invariant: `up`&`down` is never 1 in any cycle, including across reset and `en` edges.
- Changes to `vote_thr` take effect the next ACCUM cycle. Changes to `pulse_len` during a pulse have no effect until the next pulse.
- Lock counter:
  - Increments in each ACCUM cycle that does not trigger a pulse; saturates at LOCK_CNT.
  - Cleared on any pulse trigger.
  - `locked` = (counter == LOCK_CNT), registered.
  - `locked` drops on the edge that enters PULSE_UP/PULSE_DN.
  - The counter holds (does not clear) during PULSE and GUARD only if it was never cleared — it cannot be, since entry clears it. Net effect: `locked` is 0 throughout PULSE and GUARD.
- Reset mid-pulse: `up`/`down` fall asynchronously with `rst`; there is no GUARD cycle.

Test Plan:
- Reset release, `en`=1, `vote_thr`=3, `pulse_len`=4, `early`=1 for 3 cycles -> `up` high exactly 4 cycles starting the edge after the 3rd early; then 1 GUARD cycle with `up`=`down`=0 and `busy`=1; then ACCUM with vote 0.
- Alternating `early`/`late` every cycle, `vote_thr`=2, for 70 cycles -> no pulse ever; `locked`=1 after exactly 64 ACCUM cycles; then 2 late cycles -> `down` pulse and `locked`=0 on the trigger edge.
- `vote_thr`=0 and `pulse_len`=0, single `late` -> `down` high exactly 1 cycle, then 1 guard cycle.
- `early`=`late`=1 for 20 cycles, then `late`=1 only, with VOTE_W=4 and `vote_thr`=7 -> no vote change during the first 20 cycles; `down` asserts after the 7th late. Separately, 20 early cycles with `vote_thr`=7 while forcing ACCUM -> pulse on the 7th early, with the vote never exceeding +7.
- `en` dropped on the 2nd cycle of a 5-cycle `up` pulse -> `up`=0 on the next edge and state IDLE; re-enable -> ACCUM with vote 0 and `locked`=0.
- `rst` asserted asynchronously mid-`down` pulse -> `down`, `busy`, `locked` = 0 immediately, before the next clk edge; random early/late for 10k cycles -> `up`&`down` never 1.

Source files
------------

// File: rtl/cdr_cp_ctrl_if.sv
// Control bus between the bang-bang phase detector side and the charge-pump sequencer.
// The master drives the votes and settings; the slave returns the pump switches and status.
interface cdr_cp_ctrl_if #(
   parameter int VOTE_W  = 4,
   parameter int PULSE_W = 4
);
   logic                en;
   logic                early;
   logic                late;
   logic [VOTE_W-2:0]   vote_thr;
   logic [PULSE_W-1:0]  pulse_len;
   logic                up;
   logic                down;
   logic                busy;
   logic                locked;

   modport master (
      output en, early, late, vote_thr, pulse_len,
      input  up, down, busy, locked
   );

   modport slave (
      input  en, early, late, vote_thr, pulse_len,
      output up, down, busy, locked
   );
endinterface

// File: rtl/cdr_cp_ctrl.sv
// CDR charge-pump sequencer: integrates early/late votes and fires bounded, exclusive
// up/down pulses with a one-cycle guard gap; reports lock after a quiet window.
module cdr_cp_ctrl #(
   parameter int VOTE_W   = 4,
   parameter int PULSE_W  = 4,
   parameter int LOCK_CNT = 64,
   parameter int LOCK_W   = 7
) (
   input  logic         clk,
   input  logic         rst,
   cdr_cp_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ACCUM, PULSE_UP, PULSE_DN, GUARD} state_t;

   localparam int                       VMAX_I = (1 << (VOTE_W-1)) - 1;
   localparam logic signed [VOTE_W-1:0] VMAX   = VOTE_W'(VMAX_I);
   localparam logic signed [VOTE_W-1:0] VMIN   = -VMAX;
   localparam logic signed [VOTE_W-1:0] ONE    = VOTE_W'(1);
   localparam logic [LOCK_W-1:0]        LOCK_MAX = LOCK_W'(LOCK_CNT);

   state_t                     r_state;
   logic signed [VOTE_W-1:0]   r_vote;
   logic [PULSE_W-1:0]         r_pcnt;
   logic [LOCK_W-1:0]          r_lock;
   logic                       r_up;
   logic                       r_down;
   logic                       r_busy;
   logic                       r_locked;

   logic signed [VOTE_W-1:0]   w_vnext;
   logic signed [VOTE_W-1:0]   w_thr;
   logic [PULSE_W-1:0]         w_len;
   logic [LOCK_W-1:0]          w_lock_inc;
   logic                       w_trig_up;
   logic                       w_trig_dn;

   // Vote saturates symmetrically so a long one-sided run cannot wrap to the opposite sign.
   always_comb begin
      w_vnext = r_vote;
      if (bus.early && !bus.late && r_vote != VMAX)
         w_vnext = r_vote + ONE;
      else if (bus.late && !bus.early && r_vote != VMIN)
         w_vnext = r_vote - ONE;
   end

   assign w_thr      = (bus.vote_thr == '0) ? ONE : $signed({1'b0, bus.vote_thr});
   assign w_len      = (bus.pulse_len == '0) ? PULSE_W'(1) : bus.pulse_len;
   assign w_trig_up  = (w_vnext >= w_thr);
   assign w_trig_dn  = (w_vnext <= -w_thr);
   assign w_lock_inc = (r_lock == LOCK_MAX) ? r_lock : r_lock + LOCK_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_vote   <= '0;
         r_pcnt   <= '0;
         r_lock   <= '0;
         r_up     <= 1'b0;
         r_down   <= 1'b0;
         r_busy   <= 1'b0;
         r_locked <= 1'b0;
      end else if (!bus.en) begin
         r_state  <= IDLE;
         r_vote   <= '0;
         r_pcnt   <= '0;
         r_lock   <= '0;
         r_up     <= 1'b0;
         r_down   <= 1'b0;
         r_busy   <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= ACCUM;
               r_vote  <= '0;
            end
            ACCUM: begin
               r_vote <= w_vnext;
               if (w_trig_up || w_trig_dn) begin
                  r_state  <= w_trig_up ? PULSE_UP : PULSE_DN;
                  r_up     <= w_trig_up;
                  r_down   <= !w_trig_up;
                  r_busy   <= 1'b1;
                  r_pcnt   <= w_len;
                  r_lock   <= '0;
                  r_locked <= 1'b0;
               end else begin
                  r_lock   <= w_lock_inc;
                  r_locked <= (w_lock_inc == LOCK_MAX);
               end
            end
            PULSE_UP, PULSE_DN: begin
               // Counter was loaded with the width, so the output spans exactly len cycles.
               if (r_pcnt <= PULSE_W'(1)) begin
                  r_state <= GUARD;
                  r_up    <= 1'b0;
                  r_down  <= 1'b0;
               end else begin
                  r_pcnt <= r_pcnt - PULSE_W'(1);
               end
            end
            GUARD: begin
               r_state <= ACCUM;
               r_vote  <= '0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_up    <= 1'b0;
               r_down  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.up     = r_up;
   assign bus.down   = r_down;
   assign bus.busy   = r_busy;
   assign bus.locked = r_locked;

endmodule

// File: tb/tb_cdr_cp_ctrl.sv
// Scoreboarded bench for the charge-pump sequencer: each stimulus row carries the
// outputs expected after its edge, queued on drive and popped after the edge.
module tb_cdr_cp_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cdr_cp_ctrl_if #(.VOTE_W(4), .PULSE_W(4)) ifc ();

   cdr_cp_ctrl #(.VOTE_W(4), .PULSE_W(4), .LOCK_CNT(64), .LOCK_W(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   int n_err = 0;
   int n_chk = 0;
   logic [3:0] sb [$];

   function automatic logic [3:0] obs();
      return {ifc.up, ifc.down, ifc.busy, ifc.locked};
   endfunction

   // row = {en, early, late, exp_up, exp_down, exp_busy, exp_locked}
   task automatic step(input logic [6:0] r);
      ifc.en = r[6]; ifc.early = r[5]; ifc.late = r[4];
      sb.push_back(r[3:0]);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [3:0] ex;
      rst = 1'b1; ifc.en = 1'b0; ifc.early = 1'b0; ifc.late = 1'b0;
      ifc.vote_thr = '0; ifc.pulse_len = '0;
      repeat (2) @(posedge clk);
      #1; ex = 4'b0000; n_chk++;
      if (obs() !== ex) begin n_err++; $display("FAIL reset_hold got %b want %b", obs(), ex); end
      rst = 1'b0;
      step(7'b000_0000);
      ex = sb.pop_front(); n_chk++;
      if (obs() !== ex) begin n_err++; $display("FAIL reset_release got %b want %b", obs(), ex); end
   endtask

   task automatic test_basic_pulse();
      logic [6:0] t [$];
      logic [3:0] ex;
      ifc.vote_thr = 3'd3; ifc.pulse_len = 4'd4;
      t.push_back(7'b100_0000);
      t.push_back(7'b110_0000); t.push_back(7'b110_0000); t.push_back(7'b110_1010);
      repeat (3) t.push_back(7'b100_1010);
      t.push_back(7'b100_0010); t.push_back(7'b100_0000);
      // vote must have been cleared: three lates are needed to reach -3
      t.push_back(7'b101_0000); t.push_back(7'b101_0000); t.push_back(7'b101_0110);
      repeat (3) t.push_back(7'b100_0110);
      t.push_back(7'b100_0010); t.push_back(7'b000_0000);
      foreach (t[i]) begin
         step(t[i]);
         ex = sb.pop_front(); n_chk++;
         if (obs() !== ex) begin n_err++; $display("FAIL basic row %0d got %b want %b", i, obs(), ex); end
      end
   endtask

   task automatic test_lock();
      logic [6:0] t [$];
      logic [3:0] ex;
      ifc.vote_thr = 3'd2; ifc.pulse_len = 4'd2;
      t.push_back(7'b100_0000);
      for (int i = 0; i < 70; i++)
         t.push_back({1'b1, (i % 2 == 0), (i % 2 != 0), 3'b000, (i >= 63)});
      t.push_back(7'b101_0001);
      t.push_back(7'b101_0110);
      t.push_back(7'b100_0110);
      t.push_back(7'b100_0010);
      t.push_back(7'b100_0000);
      t.push_back(7'b000_0000);
      foreach (t[i]) begin
         step(t[i]);
         ex = sb.pop_front(); n_chk++;
         if (obs() !== ex) begin n_err++; $display("FAIL lock row %0d got %b want %b", i, obs(), ex); end
      end
   endtask

   task automatic test_zero_settings();
      logic [6:0] t [$];
      logic [3:0] ex;
      ifc.vote_thr = 3'd0; ifc.pulse_len = 4'd0;
      t.push_back(7'b100_0000);
      t.push_back(7'b101_0110);
      t.push_back(7'b100_0010);
      t.push_back(7'b100_0000);
      t.push_back(7'b000_0000);
      foreach (t[i]) begin
         step(t[i]);
         ex = sb.pop_front(); n_chk++;
         if (obs() !== ex) begin n_err++; $display("FAIL zero row %0d got %b want %b", i, obs(), ex); end
      end
   endtask

   task automatic test_saturation();
      logic [6:0] t [$];
      logic [3:0] ex;
      ifc.vote_thr = 3'd7; ifc.pulse_len = 4'd1;
      t.push_back(7'b100_0000);
      repeat (20) t.push_back(7'b111_0000);
      repeat (6)  t.push_back(7'b101_0000);
      t.push_back(7'b101_0110);
      t.push_back(7'b100_0010);
      t.push_back(7'b100_0000);
      repeat (6) t.push_back(7'b110_0000);
      t.push_back(7'b110_1010);
      t.push_back(7'b110_0010);
      t.push_back(7'b110_0000);
      repeat (6) t.push_back(7'b110_0000);
      t.push_back(7'b110_1010);
      t.push_back(7'b100_0010);
      t.push_back(7'b100_0000);
      t.push_back(7'b000_0000);
      foreach (t[i]) begin
         step(t[i]);
         ex = sb.pop_front(); n_chk++;
         if (obs() !== ex) begin n_err++; $display("FAIL sat row %0d got %b want %b", i, obs(), ex); end
      end
   endtask

   task automatic test_en_drop();
      logic [6:0] t [$];
      logic [3:0] ex;
      ifc.vote_thr = 3'd1; ifc.pulse_len = 4'd5;
      t.push_back(7'b100_0000);
      t.push_back(7'b110_1010);
      t.push_back(7'b000_0000);
      t.push_back(7'b100_0000);
      t.push_back(7'b101_0110);
      t.push_back(7'b000_0000);
      foreach (t[i]) begin
         step(t[i]);
         ex = sb.pop_front(); n_chk++;
         if (obs() !== ex) begin n_err++; $display("FAIL en_drop row %0d got %b want %b", i, obs(), ex); end
      end
   endtask

   task automatic test_async_reset();
      logic [6:0] t [$];
      logic [3:0] ex;
      ifc.vote_thr = 3'd1; ifc.pulse_len = 4'd5;
      t.push_back(7'b100_0000);
      t.push_back(7'b101_0110);
      t.push_back(7'b100_0110);
      foreach (t[i]) begin
         step(t[i]);
         ex = sb.pop_front(); n_chk++;
         if (obs() !== ex) begin n_err++; $display("FAIL areset row %0d got %b want %b", i, obs(), ex); end
      end
      #2 rst = 1'b1;
      #1 ex = 4'b0000; n_chk++;
      if (obs() !== ex) begin n_err++; $display("FAIL areset_immediate got %b want %b", obs(), ex); end
      ifc.en = 1'b0;
      @(negedge clk) rst = 1'b0;
      step(7'b000_0000);
      ex = sb.pop_front(); n_chk++;
      if (obs() !== ex) begin n_err++; $display("FAIL areset_after got %b want %b", obs(), ex); end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 10000; i++) begin
         ifc.en    = ($urandom_range(0, 199) != 0);
         ifc.early = $urandom_range(0, 1) == 1;
         ifc.late  = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 31) == 0) begin
            ifc.vote_thr  = 3'($urandom_range(0, 7));
            ifc.pulse_len = 4'($urandom_range(0, 6));
         end
         if (i == 5000) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
         @(posedge clk); #1;
         n_chk++;
         if ((ifc.up && ifc.down) || ((ifc.up || ifc.down) && !ifc.busy)) begin
            n_err++; bad++;
            if (bad < 10)
               $display("FAIL random cyc %0d got up=%b down=%b busy=%b want exclusive and busy", i, ifc.up, ifc.down, ifc.busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_pulse();
      test_lock();
      test_zero_settings();
      test_saturation();
      test_en_drop();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
